// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared game state encodings, defaults and helpers
package game_sequencer_pkg;

    // Renderer-visible game state encoding
    localparam logic [1:0] S_SPLASH = 2'd0;
    localparam logic [1:0] S_MIDDLE = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    // Winner encoding
    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Match and goal defaults shared with the renderer
    localparam int unsigned DEF_WIN_SCORE    = 7;
    localparam int unsigned DEF_SERVE_FRAMES = 60;
    localparam int unsigned DEF_END_FRAMES   = 180;
    localparam int unsigned DEF_GOAL_XL      = 224;
    localparam int unsigned DEF_GOAL_XR      = 704;
    localparam int unsigned DEF_GOAL_YLB     = 246;
    localparam int unsigned DEF_GOAL_YUB     = 296;

    typedef logic [3:0] score_t;
    typedef logic [9:0] coord_t;
    typedef logic [7:0] frame_cnt_t;

    localparam score_t SCORE_MAX = 4'd15;

    // Score increment that sticks at the 4-bit ceiling instead of wrapping
    function automatic score_t score_sat_inc(input score_t s);
        return (s == SCORE_MAX) ? s : s + 4'd1;
    endfunction

    // Inclusive vertical goal-mouth test
    function automatic logic in_goal_mouth(input coord_t y, input coord_t lb, input coord_t ub);
        return (y >= lb) && (y <= ub);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - bundle of game inputs and renderer-facing outputs
interface game_sequencer_if;
    import game_sequencer_pkg::*;

    logic       vsync;
    logic       btn_start;
    coord_t     puck_x;
    coord_t     puck_y;
    logic [1:0] state;
    score_t     score_1;
    score_t     score_2;
    logic       round_rst;
    logic [1:0] winner;

    // Driver side: video timing, button and puck tracker
    modport master (
        output vsync, btn_start, puck_x, puck_y,
        input  state, score_1, score_2, round_rst, winner
    );

    // Sequencer side
    modport slave (
        input  vsync, btn_start, puck_x, puck_y,
        output state, score_1, score_2, round_rst, winner
    );
endinterface

// File: rtl/game_sequencer_sync_rise.sv
// rtl/game_sequencer_sync_rise.sv - two-flop synchroniser with registered rising-edge pulse
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic pulse_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       pulse_q;
    logic       arm_q;
    logic [1:0] prime_q;

    // Synchronise, then pulse once per rising edge. The pulse is only armed
    // after the synchronised level has been seen low following reset, so an
    // input already high at reset release never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            arm_q   <= 1'b0;
            prime_q <= 2'b00;
        end else begin
            meta_q  <= din_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && !sync_q) begin
                arm_q <= 1'b1;
            end
            pulse_q <= arm_q && sync_q && !prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - match state machine: serve, play, goal scoring and end screen
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned END_FRAMES   = DEF_END_FRAMES,
    parameter int unsigned GOAL_XL      = DEF_GOAL_XL,
    parameter int unsigned GOAL_XR      = DEF_GOAL_XR,
    parameter int unsigned GOAL_YLB     = DEF_GOAL_YLB,
    parameter int unsigned GOAL_YUB     = DEF_GOAL_YUB
) (
    input  logic            clk,
    input  logic            clr_n,
    game_sequencer_if.slave gs
);

    localparam score_t     WIN_S     = score_t'(WIN_SCORE);
    localparam frame_cnt_t SERVE_CNT = frame_cnt_t'(SERVE_FRAMES);
    localparam frame_cnt_t END_CNT   = frame_cnt_t'(END_FRAMES);
    localparam coord_t     XL        = coord_t'(GOAL_XL);
    localparam coord_t     XR        = coord_t'(GOAL_XR);
    localparam coord_t     YLB       = coord_t'(GOAL_YLB);
    localparam coord_t     YUB       = coord_t'(GOAL_YUB);

    logic       frame_tick;
    logic       start_edge;

    logic [1:0] state_q,  state_d;
    frame_cnt_t cnt_q,    cnt_d;
    score_t     score1_q, score1_d;
    score_t     score2_q, score2_d;
    logic [1:0] winner_q, winner_d;

    logic       mouth;
    logic       left_goal;
    logic       right_goal;
    score_t     score1_inc;
    score_t     score2_inc;

    sync_rise u_vsync_rise (
        .clk     (clk),
        .rst_n   (clr_n),
        .din_i   (gs.vsync),
        .pulse_o (frame_tick)
    );

    sync_rise u_start_rise (
        .clk     (clk),
        .rst_n   (clr_n),
        .din_i   (gs.btn_start),
        .pulse_o (start_edge)
    );

    // Goal detection and candidate scores; left goal takes priority below
    always_comb begin
        mouth      = in_goal_mouth(gs.puck_y, YLB, YUB);
        left_goal  = mouth && (gs.puck_x <= XL);
        right_goal = mouth && (gs.puck_x >= XR);
        score1_inc = score_sat_inc(score1_q);
        score2_inc = score_sat_inc(score2_q);
    end

    // Next-state logic for match progression, frame counting and scoring
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        case (state_q)
            S_SPLASH: begin
                if (start_edge) begin
                    state_d  = S_MIDDLE;
                    cnt_d    = '0;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WIN_NONE;
                end
            end
            S_MIDDLE: begin
                if (cnt_q == SERVE_CNT) begin
                    state_d = S_PLAY;
                end else if (frame_tick) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PLAY: begin
                if (frame_tick && left_goal) begin
                    score2_d = score2_inc;
                    cnt_d    = '0;
                    if (score2_inc == WIN_S) begin
                        state_d  = S_END;
                        winner_d = WIN_P2;
                    end else begin
                        state_d  = S_MIDDLE;
                    end
                end else if (frame_tick && right_goal) begin
                    score1_d = score1_inc;
                    cnt_d    = '0;
                    if (score1_inc == WIN_S) begin
                        state_d  = S_END;
                        winner_d = WIN_P1;
                    end else begin
                        state_d  = S_MIDDLE;
                    end
                end
            end
            S_END: begin
                if (start_edge || (cnt_q == END_CNT)) begin
                    state_d = S_SPLASH;
                end else if (frame_tick) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_SPLASH;
            end
        endcase
    end

    // Registered match state; reset abandons any match in progress
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_SPLASH;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WIN_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
        end
    end

    assign gs.state     = state_q;
    assign gs.score_1   = score1_q;
    assign gs.score_2   = score2_q;
    assign gs.winner    = winner_q;
    assign gs.round_rst = (state_q != S_PLAY);

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer with a frame-level match model
module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int WIN   = 7;
    localparam int SERVE = 60;
    localparam int ENDF  = 180;
    localparam int XL    = 224;
    localparam int XR    = 704;
    localparam int YLB   = 246;
    localparam int YUB   = 296;

    typedef logic [12:0] snap_t;
    localparam snap_t RST = 13'h001;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    game_sequencer_if gs ();

    game_sequencer #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SERVE),
        .END_FRAMES   (ENDF),
        .GOAL_XL      (XL),
        .GOAL_XR      (XR),
        .GOAL_YLB     (YLB),
        .GOAL_YUB     (YUB)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .gs    (gs)
    );

    // Frame-level match model
    int m_state = 0;
    int m_cnt   = 0;
    int m_s1    = 0;
    int m_s2    = 0;
    int m_win   = 0;

    snap_t exp_q[$];
    snap_t last_pushed = RST;

    int vectors = 0;
    int miscompares = 0;

    int    req_cnt = 0;
    int    served  = 0;
    int    req_kind = 0;
    string req_name = "";
    snap_t req_exp = '0;

    bit    mon_en = 1'b0;
    snap_t prev = RST;
    snap_t cur;

    function automatic snap_t mk(input int st, input int s1, input int s2, input int w);
        return {2'(st), 4'(s1), 4'(s2), 2'(w), 1'(st != 2)};
    endfunction

    function automatic snap_t dut_snap();
        return {gs.state, gs.score_1, gs.score_2, gs.winner, gs.round_rst};
    endfunction

    function automatic snap_t model_snap();
        return mk(m_state, m_s1, m_s2, m_win);
    endfunction

    task automatic push_model();
        snap_t s;
        s = model_snap();
        if (s !== last_pushed) begin
            exp_q.push_back(s);
            last_pushed = s;
        end
    endtask

    task automatic model_press();
        if (m_state == 0) begin
            m_state = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (m_state == 3) begin
            m_state = 0;
        end
        push_model();
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
        push_model();
    endtask

    task automatic model_frame(input int x, input int y);
        bit in_y, left, right;
        in_y  = (y >= YLB) && (y <= YUB);
        left  = in_y && (x <= XL);
        right = in_y && (x >= XR);
        if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == SERVE) m_state = 2;
        end else if (m_state == 2) begin
            if (left) begin
                m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                m_cnt = 0;
                if (m_s2 == WIN) begin m_state = 3; m_win = 2; end
                else m_state = 1;
            end else if (right) begin
                m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                m_cnt = 0;
                if (m_s1 == WIN) begin m_state = 3; m_win = 1; end
                else m_state = 1;
            end
        end else if (m_state == 3) begin
            m_cnt++;
            if (m_cnt == ENDF) m_state = 0;
        end
        push_model();
    endtask

    // Hand a comparison to the monitor and let it be served at the next negedge
    task automatic req(input int kind, input string name, input snap_t e);
        req_kind = kind;
        req_name = name;
        req_exp  = e;
        req_cnt++;
        @(negedge clk);
        #1;
    endtask

    // Monitor: serves direct check requests and pops the scoreboard on every output change
    always @(negedge clk) begin
        cur = dut_snap();
        if (req_cnt != served) begin
            served = req_cnt;
            vectors++;
            if (req_kind == 0) begin
                if (cur !== req_exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", req_name, cur, req_exp);
                end
            end else if (req_kind == 1) begin
                miscompares++;
                $display("FAIL %s: got state %0d expected model state %0d", req_name, cur[12:11], m_state);
            end else begin
                if (exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL %s: got %0d pending expectations expected 0", req_name, exp_q.size());
                end
            end
        end
        if (mon_en && (cur !== prev)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got %h expected %h", cur, prev);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                if (cur !== e) begin
                    miscompares++;
                    $display("FAIL output_change: got %h expected %h", cur, e);
                end
            end
            prev = cur;
        end
    end

    task automatic do_frame(input int x, input int y);
        @(posedge clk);
        #1;
        gs.puck_x = 10'(x);
        gs.puck_y = 10'(y);
        gs.vsync  = 1'b0;
        model_frame(x, y);
        repeat (2) @(posedge clk);
        #1 gs.vsync = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        req(0, "frame_end", model_snap());
    endtask

    task automatic press();
        @(posedge clk);
        #1 gs.btn_start = 1'b1;
        model_press();
        repeat (6) @(posedge clk);
        #1;
        req(0, "after_press", model_snap());
    endtask

    task automatic release_btn();
        @(posedge clk);
        #1 gs.btn_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rand_puck(output int x, output int y);
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0, 1: begin x = int'($urandom_range(0, XL));   y = int'($urandom_range(YLB, YUB)); end
            2, 3: begin x = int'($urandom_range(XR, 799)); y = int'($urandom_range(YLB, YUB)); end
            4:    begin x = XL; y = ($urandom_range(0, 1) != 0) ? YLB : YUB; end
            5:    begin x = XR; y = ($urandom_range(0, 1) != 0) ? YLB : YUB; end
            6:    begin x = int'($urandom_range(0, XL)); y = ($urandom_range(0, 1) != 0) ? YLB - 1 : YUB + 1; end
            7:    begin x = ($urandom_range(0, 1) != 0) ? XL + 1 : XR - 1; y = int'($urandom_range(YLB, YUB)); end
            default: begin x = int'($urandom_range(XL + 1, XR - 1)); y = int'($urandom_range(0, 479)); end
        endcase
    endtask

    task automatic run_until(input int target, input int max_frames);
        int n, x, y;
        n = 0;
        while (m_state != target && n < max_frames) begin
            rand_puck(x, y);
            do_frame(x, y);
            n++;
        end
        if (m_state != target) req(1, "run_until_timeout", '0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 3 ms");
        $fatal(1, "timeout");
    end

    initial begin
        int n, x, y;
        gs.vsync = 1'b1;
        gs.btn_start = 1'b0;
        gs.puck_x = 10'd464;
        gs.puck_y = 10'd270;
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req(0, "reset_state", RST);
        mon_en = 1'b1;

        // Release reset with vsync and button both high: no tick, no start
        gs.btn_start = 1'b1;
        @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        req(0, "no_start_after_release", RST);
        release_btn();

        // Match A: button held throughout, random play to the end screen
        press();
        run_until(2, 100);
        do_frame(220, 200);
        do_frame(220, 270);
        run_until(3, 3000);
        run_until(0, 300);
        for (int i = 0; i < 4; i++) begin
            rand_puck(x, y);
            do_frame(x, y);
        end
        release_btn();

        // Match B: player 1 scores every goal, start press leaves END early
        press();
        release_btn();
        n = 0;
        while (m_state != 3 && n < 2000) begin
            if (m_state == 2) do_frame(710, 260);
            else do_frame(464, 100);
            n++;
        end
        if (m_state != 3) req(1, "match_b_timeout", '0);
        do_frame(464, 100);
        press();
        release_btn();

        // Match C: reach 3:2 in play, then abandon via reset
        press();
        release_btn();
        n = 0;
        while (!(m_state == 2 && m_s1 == 3 && m_s2 == 2) && n < 2000) begin
            if (m_state == 2) begin
                if (m_s1 < 3) do_frame(710, 270);
                else do_frame(200, 250);
            end else begin
                do_frame(464, 100);
            end
            n++;
        end
        if (!(m_state == 2 && m_s1 == 3 && m_s2 == 2)) req(1, "match_c_timeout", '0);
        @(posedge clk);
        model_reset();
        #1 clr_n = 1'b0;
        gs.btn_start = 1'b1;
        req(0, "reset_in_play", RST);
        @(posedge clk);
        #1 clr_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i % 2 == 0) do_frame(220, 270);
            else do_frame(710, 270);
        end
        release_btn();
        req(0, "idle_after_reset", RST);

        req(2, "scoreboard_drained", '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 7: score that ends a match (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60: frames held in MIDDLE before play.
REQ-003 Parameter END_FRAMES, default 180: frames held in END before auto-return to SPLASH.
REQ-004 Parameter GOAL_XL, default 224: left goal line; puck_x <= GOAL_XL is a left goal.
REQ-005 Parameter GOAL_XR, default 704: right goal line; puck_x >= GOAL_XR is a right goal.
REQ-006 Parameters GOAL_YLB / GOAL_YUB, defaults 246 / 296: goal mouth, inclusive puck_y range.
REQ-007 clk  in  1  system clock; the only clock.
REQ-008 clr_n  in  1  reset; asynchronous assert, active-low.
REQ-009 vsync  in  1  VGA vsync, active-low pulse, asynchronous to clk.
REQ-010 btn_start  in  1  debounced start button, level, active-high.
REQ-011 puck_x, puck_y  in  10 each  puck centre in hc/vc pixel coordinates.
REQ-012 state  out  2  game state: 0 splash, 1 middle, 2 play, 3 end (renderer encoding).
REQ-013 score_1, score_2  out  4 each  player scores, unsigned.
REQ-014 round_rst  out  1  high while paddles and puck are held at their start positions.
REQ-015 winner  out  2  0 none, 1 player 1, 2 player 2.

Function
REQ-016 vsync SHALL pass through a 2-flop synchroniser; frame_tick SHALL be a 1-clk pulse on the synchronised rising edge, 3 clk after the input edge.
REQ-017 btn_start SHALL be registered; start_edge SHALL be a 1-clk pulse on its rising edge; a held level SHALL never retrigger.
REQ-018 SPLASH: on start_edge -> MIDDLE; score_1, score_2, winner cleared in the same cycle.
REQ-019 MIDDLE: round_rst = 1; frame counter cleared on entry, incremented per frame_tick; at count == SERVE_FRAMES -> PLAY.
REQ-020 PLAY: round_rst = 0; goal tested only in frame_tick cycles.
REQ-021 Left goal (puck_x <= GOAL_XL, puck_y in [GOAL_YLB, GOAL_YUB]) SHALL increment score_2; right goal (puck_x >= GOAL_XR, same y range) SHALL increment score_1.
REQ-022 If both goal conditions hold in one tick, the left goal SHALL win and only one score SHALL change.
REQ-023 After a goal: incremented score == WIN_SCORE -> END with winner set; otherwise -> MIDDLE. Exactly one increment per goal.
REQ-024 Scores SHALL saturate at 15 and never wrap.
REQ-025 END: frame counter cleared on entry; at count == END_FRAMES or on start_edge -> SPLASH; scores and winner held until the next SPLASH -> MIDDLE transition.
REQ-026 start_edge SHALL be ignored in MIDDLE and PLAY.
REQ-027 state SHALL be registered and change only on clk edges; round_rst SHALL be decoded from registered state.

Reset
REQ-028 With clr_n low: state = 0, score_1 = score_2 = 0, winner = 0, round_rst = 1, frame counter = 0, synchroniser and edge registers = 0.
REQ-029 Reset asserted mid-match SHALL abandon the match; after release the block SHALL wait in SPLASH for a fresh start_edge.
REQ-030 Deassertion SHALL not generate frame_tick or start_edge, even if vsync or btn_start is high at release.

Structure
REQ-031 The state encodings (S_SPLASH = 0, S_MIDDLE = 1, S_PLAY = 2, S_END = 3) and the goal and score defaults SHALL live in a shared game package used by the renderer and this block.
REQ-032 The synchroniser and rising-edge pulse SHALL form one sub-module, sync_rise, instantiated twice (vsync, btn_start).
REQ-033 The frame counter SHALL be 8 bits; SERVE_FRAMES and END_FRAMES SHALL be <= 255.

Verification
REQ-034 Reset, then btn_start pulse -> state 0->1, round_rst = 1; after 60 vsync rising edges, state = 2, round_rst = 0.
REQ-035 In PLAY, puck = (220, 270) on a frame tick -> score_2 = 1, state = 1; puck = (220, 200) -> no score change.
REQ-036 score_1 = 6 with WIN_SCORE = 7, puck = (710, 260) on a tick -> score_1 = 7, winner = 1, state = 3; after 180 frames, state = 0.
REQ-037 btn_start held high through a full match -> only one SPLASH->MIDDLE transition; the start press in END returns to SPLASH immediately.
REQ-038 clr_n pulsed low in PLAY with score 3:2 -> all outputs at reset values within 0 clk; after release, state stays 0 with no start press.
